sda_gmem_read_splitter: RTL and testbench

- AXI4 read-channel adapter between the action core's gmem read master and the kernel's m_axi_gmem read port.
- Splits INCR read bursts that cross a 4 KB address boundary into two legal sub-bursts.
- Re-merges the R stream so the action core sees exactly one RLAST per original request.
- Single-ID, in-order traffic only.

---
 rtl/sda_gmem_read_splitter.sv | 169 ++++++++++++++++
 tb/tb_sda_gmem_read_splitter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sda_gmem_read_splitter.sv
// AXI4 read-channel adapter: splits INCR bursts that cross a 4 KB page into two
// sub-bursts and re-merges RLAST. Optional split counter: GMEM_SPLIT_COUNT_EN.
module sda_gmem_read_splitter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int TRACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_gmem_araddr,
  input  logic [7:0]            s_axi_gmem_arlen,
  input  logic [2:0]            s_axi_gmem_arsize,
  input  logic [1:0]            s_axi_gmem_arburst,
  input  logic [1:0]            s_axi_gmem_armtype,
  input  logic                  s_axi_gmem_arvalid,
  output logic                  s_axi_gmem_arready,
  output logic [DATA_WIDTH-1:0] s_axi_gmem_rdata,
  output logic [1:0]            s_axi_gmem_rresp,
  output logic                  s_axi_gmem_rlast,
  output logic                  s_axi_gmem_rvalid,
  input  logic                  s_axi_gmem_rready,
  output logic [ADDR_WIDTH-1:0] m_axi_gmem_araddr,
  output logic [7:0]            m_axi_gmem_arlen,
  output logic [2:0]            m_axi_gmem_arsize,
  output logic [1:0]            m_axi_gmem_arburst,
  output logic [1:0]            m_axi_gmem_armtype,
  output logic                  m_axi_gmem_arvalid,
  input  logic                  m_axi_gmem_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_gmem_rdata,
  input  logic [1:0]            m_axi_gmem_rresp,
  input  logic                  m_axi_gmem_rlast,
  input  logic                  m_axi_gmem_rvalid,
  output logic                  m_axi_gmem_rready,
`ifdef GMEM_SPLIT_COUNT_EN
  output logic [15:0]           split_count,
`endif
  output logic [1:0]            fsm_state
);

  localparam int PTR_W = $clog2(TRACK_DEPTH);
  localparam int CNT_W = $clog2(TRACK_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE_A = 2'd1, ISSUE_B = 2'd2} state_t;

  state_t                state;
  logic                  split_q;
  logic [ADDR_WIDTH-1:0] b_addr_q;
  logic [7:0]            b_len_q;

  logic                  trk_mem [TRACK_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  seen_first;

  logic [16:0]           span;
  logic                  do_split;
  logic [7:0]            len1, len2;
  logic                  push, pop, r_fire, head_split, ar_fire;

  // Every channel transfers on a cycle where valid && ready; a valid, once
  // raised, keeps its payload stable until that cycle.
  assign push    = s_axi_gmem_arvalid && s_axi_gmem_arready;
  assign ar_fire = m_axi_gmem_arvalid && m_axi_gmem_arready;

  // Page offset plus burst byte count exceeding 4096 means the last byte lands
  // in the next page; only INCR bursts are split.
  assign span     = 17'(s_axi_gmem_araddr[11:0]) +
                    ((17'(s_axi_gmem_arlen) + 17'd1) << s_axi_gmem_arsize);
  assign do_split = (s_axi_gmem_arburst == 2'b01) && (span > 17'h1000);
  assign len1     = 8'((13'h1000 - {1'b0, s_axi_gmem_araddr[11:0]}) >> s_axi_gmem_arsize) - 8'd1;
  assign len2     = s_axi_gmem_arlen - len1 - 8'd1;

  assign head_split = (count != '0) && trk_mem[rd_ptr];
  assign r_fire     = m_axi_gmem_rvalid && s_axi_gmem_rready;
  assign pop        = r_fire && s_axi_gmem_rlast && (count != '0);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  assign s_axi_gmem_rdata  = m_axi_gmem_rdata;
  assign s_axi_gmem_rresp  = m_axi_gmem_rresp;
  assign s_axi_gmem_rvalid = m_axi_gmem_rvalid;
  assign m_axi_gmem_rready = s_axi_gmem_rready;
  // The first sub-burst's last beat is hidden from the core.
  assign s_axi_gmem_rlast  = m_axi_gmem_rlast && (!head_split || seen_first);
  assign fsm_state         = state;

  always_ff @(posedge clk) begin
    if (push) trk_mem[wr_ptr] <= do_split;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      split_q            <= 1'b0;
      b_addr_q           <= '0;
      b_len_q            <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      seen_first         <= 1'b0;
      s_axi_gmem_arready <= 1'b0;
      m_axi_gmem_arvalid <= 1'b0;
      m_axi_gmem_araddr  <= '0;
      m_axi_gmem_arlen   <= '0;
      m_axi_gmem_arsize  <= '0;
      m_axi_gmem_arburst <= '0;
      m_axi_gmem_armtype <= '0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        seen_first <= 1'b0;
      end else if (r_fire && m_axi_gmem_rlast && head_split) begin
        seen_first <= 1'b1;
      end

      case (state)
        IDLE: begin
          s_axi_gmem_arready <= (count_next < CNT_W'(TRACK_DEPTH));
          if (push) begin
            split_q            <= do_split;
            b_addr_q           <= {s_axi_gmem_araddr[ADDR_WIDTH-1:12] + (ADDR_WIDTH-12)'(1), 12'h000};
            b_len_q            <= len2;
            m_axi_gmem_araddr  <= s_axi_gmem_araddr;
            m_axi_gmem_arlen   <= do_split ? len1 : s_axi_gmem_arlen;
            m_axi_gmem_arsize  <= s_axi_gmem_arsize;
            m_axi_gmem_arburst <= s_axi_gmem_arburst;
            m_axi_gmem_armtype <= s_axi_gmem_armtype;
            m_axi_gmem_arvalid <= 1'b1;
            s_axi_gmem_arready <= 1'b0;
            state              <= ISSUE_A;
          end
        end
        ISSUE_A: begin
          if (ar_fire) begin
            if (split_q) begin
              m_axi_gmem_araddr <= b_addr_q;
              m_axi_gmem_arlen  <= b_len_q;
              state             <= ISSUE_B;
            end else begin
              m_axi_gmem_arvalid <= 1'b0;
              s_axi_gmem_arready <= (count_next < CNT_W'(TRACK_DEPTH));
              state              <= IDLE;
            end
          end
        end
        ISSUE_B: begin
          if (ar_fire) begin
            m_axi_gmem_arvalid <= 1'b0;
            s_axi_gmem_arready <= (count_next < CNT_W'(TRACK_DEPTH));
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GMEM_SPLIT_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      split_count <= '0;
    end else if (state == ISSUE_B && ar_fire && split_count != 16'hFFFF) begin
      split_count <= split_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sda_gmem_read_splitter.sv
// Directed bench for sda_gmem_read_splitter: page-split model, per-cycle compare,
// literal checks of the issued AR sequence. Honours GMEM_SPLIT_COUNT_EN.
module tb_sda_gmem_read_splitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [2:0]  s_arsize = '0;
  logic [1:0]  s_arburst = '0;
  logic [1:0]  s_armtype = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast, s_rvalid;
  logic        s_rready = 1'b1;
  logic [63:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_armtype;
  logic        m_arvalid;
  logic        m_arready = 1'b1;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rlast = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic [1:0]  fsm_state;
`ifdef GMEM_SPLIT_COUNT_EN
  logic [15:0] split_count;
`endif

  sda_gmem_read_splitter dut (
    .clk(clk), .reset(reset),
    .s_axi_gmem_araddr(s_araddr), .s_axi_gmem_arlen(s_arlen), .s_axi_gmem_arsize(s_arsize),
    .s_axi_gmem_arburst(s_arburst), .s_axi_gmem_armtype(s_armtype),
    .s_axi_gmem_arvalid(s_arvalid), .s_axi_gmem_arready(s_arready),
    .s_axi_gmem_rdata(s_rdata), .s_axi_gmem_rresp(s_rresp), .s_axi_gmem_rlast(s_rlast),
    .s_axi_gmem_rvalid(s_rvalid), .s_axi_gmem_rready(s_rready),
    .m_axi_gmem_araddr(m_araddr), .m_axi_gmem_arlen(m_arlen), .m_axi_gmem_arsize(m_arsize),
    .m_axi_gmem_arburst(m_arburst), .m_axi_gmem_armtype(m_armtype),
    .m_axi_gmem_arvalid(m_arvalid), .m_axi_gmem_arready(m_arready),
    .m_axi_gmem_rdata(m_rdata), .m_axi_gmem_rresp(m_rresp), .m_axi_gmem_rlast(m_rlast),
    .m_axi_gmem_rvalid(m_rvalid), .m_axi_gmem_rready(m_rready),
`ifdef GMEM_SPLIT_COUNT_EN
    .split_count(split_count),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  mtype;
    bit          second;
  } ar_t;

  ar_t         exp_q[$];       // expected downstream AR transfers, in order
  int          rq[$];          // beats per outstanding original request
  logic [63:0] log_addr[$];    // observed downstream AR addresses
  logic [7:0]  log_len[$];
  logic [1:0]  log_burst[$];
  int          r_cnt = 0;
  int          rlast_seen = 0;
  int          exp_splits = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected downstream requests from the page rule, in plain byte arithmetic.
  task automatic model_push(input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [1:0] mtype);
    longint unsigned beat_bytes, bytes, off, n1;
    beat_bytes = 64'd1 << size;
    bytes = (longint'(len) + 1) * beat_bytes;
    off = addr % 4096;
    if (burst == 2'b01 && off + bytes > 4096) begin
      n1 = (4096 - off) / beat_bytes;
      exp_q.push_back('{addr, 8'(n1 - 1), size, burst, mtype, 1'b0});
      exp_q.push_back('{(addr / 4096 + 1) * 4096, 8'(longint'(len) - n1), size, burst, mtype, 1'b1});
    end else begin
      exp_q.push_back('{addr, len, size, burst, mtype, 1'b0});
    end
    rq.push_back(int'(len) + 1);
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic        prev_stall;
    logic [63:0] p_addr;
    logic [7:0]  p_len;
    logic [2:0]  p_size;
    logic [1:0]  p_burst, p_mtype;
    bit          exp_last;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        chk("r_valid_pass", {s_rvalid, m_rready}, {m_rvalid, s_rready});
        if (m_rvalid) chk("r_data_pass", {s_rdata, s_rresp}, {m_rdata, m_rresp});
        if (m_rvalid && s_rready) begin
          if (rq.size() == 0) begin
            exp_last = m_rlast;
          end else begin
            r_cnt++;
            exp_last = (r_cnt == rq[0]);
          end
          chk("r_last", s_rlast, exp_last);
          if (s_rlast) rlast_seen++;
          if (rq.size() != 0 && exp_last) begin
            void'(rq.pop_front());
            r_cnt = 0;
          end
        end
        if (prev_stall)
          chk("ar_stable", {m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_armtype},
              {1'b1, p_addr, p_len, p_size, p_burst, p_mtype});
        if (m_arvalid && m_arready) begin
          log_addr.push_back(m_araddr);
          log_len.push_back(m_arlen);
          log_burst.push_back(m_arburst);
          if (exp_q.size() == 0) begin
            chk("ar_unexpected", 1'b1, 1'b0);
          end else begin
            chk("ar_fields", {m_araddr, m_arlen, m_arsize, m_arburst, m_armtype},
                {exp_q[0].addr, exp_q[0].len, exp_q[0].size, exp_q[0].burst, exp_q[0].mtype});
            if (exp_q[0].second) exp_splits++;
            void'(exp_q.pop_front());
          end
        end
        prev_stall = m_arvalid && !m_arready;
        p_addr = m_araddr; p_len = m_arlen; p_size = m_arsize;
        p_burst = m_arburst; p_mtype = m_armtype;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [1:0] mtype);
    int w;
    s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst; s_armtype = mtype;
    s_arvalid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!s_arready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!s_arready) begin
      chk("ar_accept_timeout", 1'b0, 1'b1);
      s_arvalid = 1'b0;
      return;
    end
    model_push(addr, len, size, burst, mtype);
    @(posedge clk);
    #1;
    s_arvalid = 1'b0;
    chk("ar_latency", m_arvalid, 1'b1);
  endtask

  task automatic downstream_burst(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = $urandom;
      m_rresp  = 2'($urandom_range(0, 3));
      m_rlast  = (i == n - 1);
      w = 0;
      @(negedge clk);
      while (!s_rready && w < 200) begin
        w++;
        @(negedge clk);
      end
      if (!s_rready) chk("r_ready_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_len.delete();
    log_burst.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    // reset values
    idle(2);
    @(negedge clk);
    chk("rst_arready", s_arready, 1'b0);
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_ar_fields", {m_araddr, m_arlen, m_arsize, m_arburst, m_armtype}, 79'd0);
    chk("rst_state", fsm_state, 2'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    @(negedge clk);
    chk("idle_arready", s_arready, 1'b1);
    @(posedge clk); #1;

    // single page, no split
    clear_log();
    base = rlast_seen;
    send_req(64'h1000, 8'd15, 3'd2, 2'b01, 2'd3);
    downstream_burst(16);
    idle(2);
    chk("t1_ar_count", log_addr.size(), 1);
    chk("t1_rlast_count", rlast_seen - base, 1);

    // stray beat with nothing outstanding: rlast passes straight through
    downstream_burst(1);

    // 4 KB crossing, size 2
    clear_log();
    base = rlast_seen;
    send_req(64'h0FF0, 8'd7, 3'd2, 2'b01, 2'd1);
    downstream_burst(4);
    downstream_burst(4);
    idle(2);
    chk("t2_ar_count", log_addr.size(), 2);
    chk("t2_ar1", {log_addr[0], log_len[0]}, {64'h0FF0, 8'd3});
    chk("t2_ar2", {log_addr[1], log_len[1]}, {64'h1000, 8'd3});
    chk("t2_rlast_count", rlast_seen - base, 1);

    // crossing with downstream stall
    clear_log();
    m_arready = 1'b0;
    send_req(64'h1FFC, 8'd255, 3'd2, 2'b01, 2'd0);
    idle(5);
    @(negedge clk);
    chk("t3_stall_fields", {m_arvalid, m_araddr, m_arlen}, {1'b1, 64'h1FFC, 8'd0});
    @(posedge clk); #1;
    m_arready = 1'b1;
    idle(3);
    chk("t3_ar1", {log_addr[0], log_len[0]}, {64'h1FFC, 8'd0});
    chk("t3_ar2", {log_addr[1], log_len[1]}, {64'h2000, 8'd254});
    downstream_burst(1);
    downstream_burst(255);

    // size 3 crossing and an exact page-end non-crossing burst
    send_req(64'h0FC0, 8'd15, 3'd3, 2'b01, 2'd2);
    send_req(64'h0FC0, 8'd15, 3'd2, 2'b01, 2'd2);
    downstream_burst(8);
    downstream_burst(8);
    downstream_burst(16);
    idle(2);

    // tracker full
    for (int i = 0; i < 8; i++) send_req(64'h3000 + 64'(i * 4), 8'd0, 3'd2, 2'b01, 2'd0);
    idle(2);
    s_araddr = 64'h4000; s_arlen = 8'd0; s_arburst = 2'b01; s_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_arready", s_arready, 1'b0);
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    downstream_burst(1);
    @(negedge clk);
    chk("slot_freed_arready", s_arready, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) downstream_burst(1);

    // WRAP burst is never split
    clear_log();
    base = rlast_seen;
    send_req(64'h0FF0, 8'd7, 3'd2, 2'b10, 2'd0);
    downstream_burst(8);
    idle(2);
    chk("wrap_ar", {log_addr.size() == 1, log_addr[0], log_len[0], log_burst[0]},
        {1'b1, 64'h0FF0, 8'd7, 2'b10});
    chk("wrap_rlast_count", rlast_seen - base, 1);

`ifdef GMEM_SPLIT_COUNT_EN
    chk("split_count_lit", split_count, 16'd3);
    chk("split_count_model", split_count, 16'(exp_splits));
`endif

    // reset in the middle of a stalled split request
    m_arready = 1'b0;
    send_req(64'h0FF0, 8'd7, 3'd2, 2'b01, 2'd1);
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ar", {s_arready, m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_armtype},
        81'd0);
    chk("midrst_state", fsm_state, 2'd0);
`ifdef GMEM_SPLIT_COUNT_EN
    chk("midrst_split_count", split_count, 16'd0);
`endif
    exp_q.delete();
    rq.delete();
    r_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_arready = 1'b1;
    idle(2);

    // recovery after reset
    base = rlast_seen;
    send_req(64'h2000, 8'd3, 3'd2, 2'b01, 2'd0);
    downstream_burst(4);
    idle(2);
    chk("recover_rlast_count", rlast_seen - base, 1);
    chk("exp_ar_drained", exp_q.size(), 0);
    chk("tracker_drained", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
